wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM result interface: consumes the `we`/write-address/write-data triple driven by the memory stage and commits it into the architectural general-purpose register file.
- Provides two read ports to the decode stage, hardwires register 0 to zero, and keeps a retired-write counter for debug and performance visibility.
- Sits between the memory stage output and the decode stage operand fetch.

Parameters:
- DATA_W, 32, register width in bits (matches RegBus).
- ADDR_W, 5, register address width (matches RegAddrBus).
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- we_i  input  1  write enable from the memory stage.
- w_addr_i  input  ADDR_W  destination register from the memory stage.
- w_data_i  input  DATA_W  write-back data from the memory stage.
- re1_i  input  1  read port 1 enable.
- raddr1_i  input  ADDR_W  read port 1 address.
- rdata1_o  output  DATA_W  read port 1 data (combinational).
- re2_i  input  1  read port 2 enable.
- raddr2_i  input  ADDR_W  read port 2 address.
- rdata2_o  output  DATA_W  read port 2 data (combinational).
- wb_cnt_o  output  CNT_W  number of committed writes to nonzero registers since reset (registered).
- wb_last_addr_o  output  ADDR_W  address of the most recent committed write (registered).

Behaviour:
- Reset, rst=0 at a rising edge:
  - All NUM_REGS entries clear to 0.
  - wb_cnt_o and wb_last_addr_o clear to 0.
  - rdata1_o and rdata2_o are forced to 0 combinationally while rst=0.
  - A write presented in the same cycle is discarded.
- Write, rst=1 and we_i=1 and w_addr_i!=0:
  - regs[w_addr_i] <= w_data_i at the rising edge; the new value is visible in the array from the next cycle.
  - wb_cnt_o increments by 1, wrapping modulo 2**CNT_W (all-ones goes to 0, no saturation).
  - wb_last_addr_o <= w_addr_i.
- Write to register 0: ignored. The array, wb_cnt_o and wb_last_addr_o are all unchanged.
- we_i=0: no state change, regardless of w_addr_i/w_data_i.
- Read priority per port, checked in this order:
  1. rst=0 → 0.
  2. re=0 → 0.
  3. raddr=0 → 0.
  4. Bypass hit (see Optional Feature) → w_data_i.
  5. Otherwise → regs[raddr].
- Both ports are independent. The same address on both ports returns identical data.
- Read latency: zero cycles (combinational from address to data). Write-to-array latency: one edge.
- Simultaneous write and read of the same register without bypass: the read returns the old value this cycle and the new value next cycle.
- Reset asserted mid-stream: takes effect at the next edge. Any in-flight write in that cycle is lost, and the counter restarts from 0.
- No back-pressure: every valid write is accepted every cycle. Back-to-back writes to the same register: the last one wins, and each counts once.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: write-through forwarding. A read port returns w_data_i when rst=1, we_i=1, w_addr_i!=0, re=1 and raddr==w_addr_i. This removes the one-cycle WB→ID hazard.
- Undefined: no forwarding. Reads always return array contents, and the pipeline must stall or forward externally.
- Array, counter and last-address behaviour are identical in both builds.

Test Plan:
- Hold rst=0 for 2 cycles after preloading r5=0xDEADBEEF, then set rst=1 and read raddr1=5 with re1=1 → rdata1=0, wb_cnt=0, wb_last_addr=0.
- Write r3=0x12345678 at edge N, read r3 on both ports at cycle N+1 → both rdata = 0x12345678, wb_cnt=1, wb_last_addr=3.
- Write r0=0xFFFFFFFF, then read r0 with re1=1 → rdata1=0, wb_cnt unchanged.
- Drive we_i=1, w_addr_i=7, w_data_i=0xA5A5A5A5 while reading raddr2=7 in the same cycle (r7 previously 0x1):
  - With WB_BYPASS_EN → rdata2=0xA5A5A5A5.
  - Without WB_BYPASS_EN → 0x1, then 0xA5A5A5A5 in the next cycle.
- Read r9 (holding 0x55) with re2=0 → rdata2=0. Set re2=1 → rdata2=0x55.
- With CNT_W=4, perform 17 writes to r1 → wb_cnt=1 (wrap). Assert rst=0 mid-sequence → the next cycle shows wb_cnt=0 and r1=0.

Source files
------------

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : Write-back commit into the GPR file, two combinational read
//             ports, r0 hardwired to zero, retired-write counter.
//  Option   : define WB_BYPASS_EN to forward w_data_i to matching reads.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [CNT_W-1:0]  wb_cnt_o,
    output logic [ADDR_W-1:0] wb_last_addr_o
);

`ifdef WB_BYPASS_EN
    localparam bit C_BYPASS = 1'b1;
`else
    localparam bit C_BYPASS = 1'b0;
`endif

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  wb_cnt_q;
    logic [CNT_W-1:0]  wb_cnt_d;
    logic [ADDR_W-1:0] wb_last_addr_q;
    logic [ADDR_W-1:0] wb_last_addr_d;

    logic              w_commit;
    logic              w_re    [2];
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];

    // Only writes to a nonzero register while out of reset retire.
    assign w_commit = rst & we_i & (w_addr_i != '0);

    always_comb begin
        wb_cnt_d       = wb_cnt_q;
        wb_last_addr_d = wb_last_addr_q;
        if (w_commit) begin
            wb_cnt_d       = wb_cnt_q + C_CNT_ONE;
            wb_last_addr_d = w_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_cnt_q       <= '0;
            wb_last_addr_q <= '0;
        end else begin
            if (w_commit) begin
                regs_q[w_addr_i] <= w_data_i;
            end
            wb_cnt_q       <= wb_cnt_d;
            wb_last_addr_q <= wb_last_addr_d;
        end
    end

    assign w_re[0]    = re1_i;
    assign w_re[1]    = re2_i;
    assign w_raddr[0] = raddr1_i;
    assign w_raddr[1] = raddr2_i;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd
            logic w_hit;

            assign w_hit = C_BYPASS & w_commit & (w_raddr[p] == w_addr_i);

            // Priority: reset, disabled port, r0, forwarded write, array.
            always_comb begin
                w_rdata[p] = '0;
                if (rst && w_re[p] && (w_raddr[p] != '0)) begin
                    if (w_hit) begin
                        w_rdata[p] = w_data_i;
                    end else begin
                        w_rdata[p] = regs_q[w_raddr[p]];
                    end
                end
            end
        end
    endgenerate

    assign rdata1_o       = w_rdata[0];
    assign rdata2_o       = w_rdata[1];
    assign wb_cnt_o       = wb_cnt_q;
    assign wb_last_addr_o = wb_last_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Directed self-checking bench for wb_regfile (default and 4-bit
//             counter instances driven in lockstep).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;

    logic [31:0] rdata1, rdata2, cnt;
    logic [4:0]  last;
    logic [31:0] rdata1_c4, rdata2_c4;
    logic [3:0]  cnt_c4;
    logic [4:0]  last_c4;

    int n_checks = 0;
    int n_errors = 0;

    wb_regfile dut (
        .clk(clk), .rst(rst), .we_i(we), .w_addr_i(w_addr), .w_data_i(w_data),
        .re1_i(re1), .raddr1_i(raddr1), .rdata1_o(rdata1),
        .re2_i(re2), .raddr2_i(raddr2), .rdata2_o(rdata2),
        .wb_cnt_o(cnt), .wb_last_addr_o(last)
    );

    wb_regfile #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .we_i(we), .w_addr_i(w_addr), .w_data_i(w_data),
        .re1_i(re1), .raddr1_i(raddr1), .rdata1_o(rdata1_c4),
        .re2_i(re2), .raddr2_i(raddr2), .rdata2_o(rdata2_c4),
        .wb_cnt_o(cnt_c4), .wb_last_addr_o(last_c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        we     = en;
        w_addr = a;
        w_data = d;
    endtask

    initial begin
        rst = 1'b0; re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        drive_wr(1'b0, 5'd0, 32'h0);
        tick();

        // Preload r5 and confirm it landed.
        rst = 1'b1;
        drive_wr(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive_wr(1'b0, 5'd0, 32'h0);
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        check("preload_r5", rdata1, 32'hDEADBEEF);
        check("preload_cnt", cnt, 32'd1);
        check("preload_last", {27'd0, last}, 32'd5);

        // Two reset cycles with a write presented that must be dropped.
        rst = 1'b0;
        drive_wr(1'b1, 5'd4, 32'h44444444);
        #1;
        check("rst_forces_rd1", rdata1, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        drive_wr(1'b0, 5'd0, 32'h0);
        re2 = 1'b1; raddr2 = 5'd4;
        #1;
        check("post_rst_r5", rdata1, 32'h0);
        check("post_rst_r4", rdata2, 32'h0);
        check("post_rst_cnt", cnt, 32'd0);
        check("post_rst_cnt_c4", {28'd0, cnt_c4}, 32'd0);
        check("post_rst_last", {27'd0, last}, 32'd0);

        // Write r3, read on both ports next cycle.
        drive_wr(1'b1, 5'd3, 32'h12345678);
        tick();
        drive_wr(1'b0, 5'd0, 32'h0);
        raddr1 = 5'd3; raddr2 = 5'd3;
        #1;
        check("r3_port1", rdata1, 32'h12345678);
        check("r3_port2", rdata2, 32'h12345678);
        check("r3_cnt", cnt, 32'd1);
        check("r3_last", {27'd0, last}, 32'd3);

        // Write to r0 is ignored entirely.
        drive_wr(1'b1, 5'd0, 32'hFFFFFFFF);
        tick();
        drive_wr(1'b0, 5'd0, 32'h0);
        raddr1 = 5'd0;
        #1;
        check("r0_read", rdata1, 32'h0);
        check("r0_cnt", cnt, 32'd1);
        check("r0_last", {27'd0, last}, 32'd3);

        // Same-cycle write/read of r7.
        drive_wr(1'b1, 5'd7, 32'h00000001);
        tick();
        drive_wr(1'b1, 5'd7, 32'hA5A5A5A5);
        raddr2 = 5'd7; raddr1 = 5'd3;
        #1;
`ifdef WB_BYPASS_EN
        check("r7_same_cycle", rdata2, 32'hA5A5A5A5);
`else
        check("r7_same_cycle", rdata2, 32'h00000001);
`endif
        check("r3_unaffected", rdata1, 32'h12345678);
        tick();
        drive_wr(1'b0, 5'd0, 32'h0);
        #1;
        check("r7_next_cycle", rdata2, 32'hA5A5A5A5);
        check("r7_cnt", cnt, 32'd3);
        check("r7_last", {27'd0, last}, 32'd7);

        // Read enable gating on port 2.
        drive_wr(1'b1, 5'd9, 32'h00000055);
        tick();
        drive_wr(1'b0, 5'd9, 32'hCAFEF00D);
        re2 = 1'b0; raddr2 = 5'd9;
        #1;
        check("r9_re_off", rdata2, 32'h0);
        re2 = 1'b1;
        #1;
        check("r9_re_on", rdata2, 32'h00000055);
        tick();
        check("we0_no_change", rdata2, 32'h00000055);
        check("we0_cnt", cnt, 32'd4);

        // Counter wrap on the 4-bit instance.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        re1 = 1'b1; raddr1 = 5'd1;
        for (int i = 0; i < 17; i++) begin
            drive_wr(1'b1, 5'd1, 32'(i + 1));
            tick();
            if (i == 15) begin
                check("wrap16_cnt", cnt, 32'd16);
                check("wrap16_cnt_c4", {28'd0, cnt_c4}, 32'd0);
            end
        end
        drive_wr(1'b0, 5'd0, 32'h0);
        #1;
        check("wrap17_cnt", cnt, 32'd17);
        check("wrap17_cnt_c4", {28'd0, cnt_c4}, 32'd1);
        check("wrap17_r1", rdata1, 32'd17);
        check("wrap17_last", {27'd0, last_c4}, 32'd1);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) begin
            drive_wr(1'b1, 5'd1, 32'h100 + 32'(i));
            tick();
        end
        drive_wr(1'b0, 5'd0, 32'h0);
        #1;
        check("burst_r1", rdata1, 32'h00000102);
        check("burst_cnt_c4", {28'd0, cnt_c4}, 32'd4);
        rst = 1'b0;
        drive_wr(1'b1, 5'd1, 32'h00000BAD);
        #1;
        check("midrst_forced", rdata1, 32'h0);
        tick();
        rst = 1'b1;
        drive_wr(1'b0, 5'd0, 32'h0);
        #1;
        check("midrst_r1", rdata1, 32'h0);
        check("midrst_cnt", cnt, 32'd0);
        check("midrst_cnt_c4", {28'd0, cnt_c4}, 32'd0);
        check("midrst_last", {27'd0, last}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
